// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared board geometry and placement-search state encoding
package tetris_pkg;

    localparam int BOARD_ROWS = 20;
    localparam int BOARD_COLS = 10;
    localparam int NUM_ROT    = 4;
    localparam int BOARD_BITS = BOARD_ROWS * BOARD_COLS;
    localparam int LAST_COL   = BOARD_COLS - 1;
    localparam int LAST_ROT   = NUM_ROT - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_SCORE,
        S_DONE
    } search_state_t;

    // Board bit for (row, col); row 0 is the top of the well.
    function automatic int bit_idx(input int row, input int col);
        return row * BOARD_COLS + col;
    endfunction

endpackage

// File: rtl/board_height_eval.sv
// rtl/board_height_eval.sv - combinational aggregate column height of a board
// Ports:
//   board  in  200 : board bits, bit row*10+col, row 0 at top
//   height out 8   : sum over columns of (20 - topmost set row), 0 for empty columns
module board_height_eval
    import tetris_pkg::*;
(
    input  logic [BOARD_BITS-1:0] board,
    output logic [7:0]            height
);

    logic [4:0] col_h;
    logic [7:0] total;

    always_comb begin
        total = '0;
        col_h = '0;
        for (int c = 0; c < BOARD_COLS; c++) begin
            col_h = '0;
            // Scan bottom-up so the last hit is the topmost set row.
            for (int r = BOARD_ROWS - 1; r >= 0; r--) begin
                if (board[bit_idx(r, c)]) begin
                    col_h = 5'(BOARD_ROWS - r);
                end
            end
            total = total + {3'b000, col_h};
        end
    end

    assign height = total;

endmodule

// File: rtl/move_search_ctrl.sv
// rtl/move_search_ctrl.sv - exhaustive rotation/column placement search over the board simulator
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   start, cur_block, cur_board: search request and the position to search from
//   busy, done, found, error   : status; done is a one-cycle pulse
//   best_col/rot/board/cleared/score : winning placement and its simulated result
//   sim_request/block/col/rotation/board : request to the board simulator
//   sim_ready/valid/next_board/cleared_lines : simulator response
module move_search_ctrl
    import tetris_pkg::*;
#(
    parameter int W_CLEAR     = 32,
    parameter int SCORE_W     = 16,
    parameter int SIM_TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [3:0]                cur_block,
    input  logic [BOARD_BITS-1:0]     cur_board,
    output logic                      busy,
    output logic                      done,
    output logic                      found,
    output logic                      error,
    output logic [3:0]                best_col,
    output logic [1:0]                best_rot,
    output logic [BOARD_BITS-1:0]     best_board,
    output logic [9:0]                best_cleared,
    output logic signed [SCORE_W-1:0] best_score,
    output logic                      sim_request,
    output logic [3:0]                sim_block,
    output logic [3:0]                sim_col,
    output logic [1:0]                sim_rotation,
    output logic [BOARD_BITS-1:0]     sim_board,
    input  logic                      sim_ready,
    input  logic                      sim_valid,
    input  logic [BOARD_BITS-1:0]     sim_next_board,
    input  logic [9:0]                sim_cleared_lines
);

    localparam int TMO_W = $clog2(SIM_TIMEOUT + 1);
    localparam logic signed [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

    search_state_t             state_q, state_d;
    logic                      pend_q, pend_d;
    logic [3:0]                blk_q, blk_d;
    logic [BOARD_BITS-1:0]     board_q, board_d;
    logic [1:0]                rot_q, rot_d;
    logic [3:0]                col_q, col_d;
    logic [TMO_W-1:0]          tmo_q, tmo_d;
    logic                      res_valid_q, res_valid_d;
    logic [BOARD_BITS-1:0]     res_board_q, res_board_d;
    logic [9:0]                res_cleared_q, res_cleared_d;
    logic                      found_q, found_d;
    logic                      error_q, error_d;
    logic signed [SCORE_W-1:0] best_q, best_d;
    logic [3:0]                best_col_q, best_col_d;
    logic [1:0]                best_rot_q, best_rot_d;
    logic [BOARD_BITS-1:0]     best_board_q, best_board_d;
    logic [9:0]                best_cleared_q, best_cleared_d;

    logic [7:0]                height;
    logic [SCORE_W-1:0]        raw_score;
    logic signed [SCORE_W-1:0] score;

    board_height_eval u_height (
        .board  (res_board_q),
        .height (height)
    );

    assign raw_score = SCORE_W'(W_CLEAR) * SCORE_W'(res_cleared_q) - SCORE_W'(height);
    assign score     = $signed(raw_score);

    always_comb begin
        state_d        = state_q;
        pend_d         = pend_q;
        blk_d          = blk_q;
        board_d        = board_q;
        rot_d          = rot_q;
        col_d          = col_q;
        tmo_d          = tmo_q;
        res_valid_d    = res_valid_q;
        res_board_d    = res_board_q;
        res_cleared_d  = res_cleared_q;
        found_d        = found_q;
        error_d        = error_q;
        best_d         = best_q;
        best_col_d     = best_col_q;
        best_rot_d     = best_rot_q;
        best_board_d   = best_board_q;
        best_cleared_d = best_cleared_q;

        case (state_q)
            S_IDLE: begin
                // The request is registered for one cycle before the search starts,
                // so busy rises one edge after start is sampled.
                if (pend_q) begin
                    pend_d  = 1'b0;
                    state_d = S_ISSUE;
                end else if (start) begin
                    pend_d         = 1'b1;
                    blk_d          = cur_block;
                    board_d        = cur_board;
                    rot_d          = '0;
                    col_d          = '0;
                    found_d        = 1'b0;
                    error_d        = 1'b0;
                    best_d         = SCORE_MIN;
                    best_col_d     = '0;
                    best_rot_d     = '0;
                    best_board_d   = '0;
                    best_cleared_d = '0;
                end
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (sim_ready) begin
                    res_valid_d   = sim_valid;
                    res_board_d   = sim_next_board;
                    res_cleared_d = sim_cleared_lines;
                    state_d       = S_SCORE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (tmo_q == TMO_W'(SIM_TIMEOUT - 1)) begin
                        error_d        = 1'b1;
                        found_d        = 1'b0;
                        best_d         = SCORE_MIN;
                        best_col_d     = '0;
                        best_rot_d     = '0;
                        best_board_d   = '0;
                        best_cleared_d = '0;
                        state_d        = S_DONE;
                    end
                end
            end
            S_SCORE: begin
                // Strict compare: the earliest candidate keeps a tie.
                if (res_valid_q && (score > best_q)) begin
                    found_d        = 1'b1;
                    best_d         = score;
                    best_col_d     = col_q;
                    best_rot_d     = rot_q;
                    best_board_d   = res_board_q;
                    best_cleared_d = res_cleared_q;
                end
                state_d = S_ISSUE;
                if (col_q == 4'(LAST_COL)) begin
                    col_d = '0;
                    if (rot_q == 2'(LAST_ROT)) begin
                        state_d = S_DONE;
                    end else begin
                        rot_d = rot_q + 2'd1;
                    end
                end else begin
                    col_d = col_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            pend_q         <= 1'b0;
            blk_q          <= '0;
            board_q        <= '0;
            rot_q          <= '0;
            col_q          <= '0;
            tmo_q          <= '0;
            res_valid_q    <= 1'b0;
            res_board_q    <= '0;
            res_cleared_q  <= '0;
            found_q        <= 1'b0;
            error_q        <= 1'b0;
            best_q         <= '0;
            best_col_q     <= '0;
            best_rot_q     <= '0;
            best_board_q   <= '0;
            best_cleared_q <= '0;
        end else begin
            state_q        <= state_d;
            pend_q         <= pend_d;
            blk_q          <= blk_d;
            board_q        <= board_d;
            rot_q          <= rot_d;
            col_q          <= col_d;
            tmo_q          <= tmo_d;
            res_valid_q    <= res_valid_d;
            res_board_q    <= res_board_d;
            res_cleared_q  <= res_cleared_d;
            found_q        <= found_d;
            error_q        <= error_d;
            best_q         <= best_d;
            best_col_q     <= best_col_d;
            best_rot_q     <= best_rot_d;
            best_board_q   <= best_board_d;
            best_cleared_q <= best_cleared_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign sim_request  = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign sim_block    = blk_q;
    assign sim_board    = board_q;
    assign sim_col      = col_q;
    assign sim_rotation = rot_q;
    assign found        = found_q;
    assign error        = error_q;
    assign best_col     = best_col_q;
    assign best_rot     = best_rot_q;
    assign best_board   = best_board_q;
    assign best_cleared = best_cleared_q;
    assign best_score   = found_q ? best_q : '0;

endmodule

// File: tb/tb_move_search_ctrl.sv
// tb/tb_move_search_ctrl.sv - directed self-checking bench for move_search_ctrl
module tb_move_search_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   cur_block = '0;
    logic [199:0] cur_board = '0;
    logic         busy, done, found, error;
    logic [3:0]   best_col;
    logic [1:0]   best_rot;
    logic [199:0] best_board;
    logic [9:0]   best_cleared;
    logic signed [15:0] best_score;
    logic         sim_request;
    logic [3:0]   sim_block, sim_col;
    logic [1:0]   sim_rotation;
    logic [199:0] sim_board;
    logic         sim_ready = 1'b0;
    logic         sim_valid = 1'b0;
    logic [199:0] sim_next_board = '0;
    logic [9:0]   sim_cleared_lines = '0;

    int  checks = 0;
    int  errors = 0;
    int  mode = 0;
    bit  stray = 1'b0;
    int  req_cycles = 0;
    int  req_pulses = 0;
    int  wait_cyc = -1;
    int  cyc = 0;
    int  done_at;
    logic prev_req = 1'b0;
    logic [199:0] board_a, board_e, exp_b0, exp_b3;

    move_search_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cur_block(cur_block), .cur_board(cur_board),
        .busy(busy), .done(done), .found(found), .error(error),
        .best_col(best_col), .best_rot(best_rot), .best_board(best_board),
        .best_cleared(best_cleared), .best_score(best_score),
        .sim_request(sim_request), .sim_block(sim_block), .sim_col(sim_col),
        .sim_rotation(sim_rotation), .sim_board(sim_board),
        .sim_ready(sim_ready), .sim_valid(sim_valid), .sim_next_board(sim_next_board),
        .sim_cleared_lines(sim_cleared_lines)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Stub simulator responses per mode (hand-chosen so winners are known).
    function automatic void stub_resp(input int m, input int rot, input int col,
                                      output logic v, output logic [9:0] cl, output logic [199:0] b);
        b = '0; v = 1'b1; cl = '0;
        case (m)
            0: begin
                if (rot == 1 && col == 7) begin
                    cl = 10'd2; b[100] = 1'b1; b[150] = 1'b1; b[199] = 1'b1;
                end else if (rot == 3 && col == 9) begin
                    cl = 10'd3;
                    for (int r = 0; r < 20; r++) begin b[r*10+2] = 1'b1; b[r*10+3] = 1'b1; end
                    for (int c = 0; c < 10; c++) b[190+c] = 1'b1;
                end else begin
                    cl = 10'd1;
                    for (int c = 0; c < 10; c++) b[190+c] = 1'b1;
                end
            end
            1: v = 1'b0;
            2: cl = (rot == 2 && col == 5) ? 10'd2 : 10'd1;
            3: for (int c = 0; c < 4; c++) b[190+c] = 1'b1;
            default: cl = 10'd1;
        endcase
    endfunction

    // One-cycle simulator: ready in the first WAIT cycle; mode 4 stalls candidate 5.
    always @(negedge clk) begin
        if (sim_request && !prev_req) req_pulses++;
        prev_req = sim_request;
        req_cycles = sim_request ? req_cycles + 1 : 0;
        stub_resp(mode, int'(sim_rotation), int'(sim_col), sim_valid, sim_cleared_lines, sim_next_board);
        if (mode == 4 && sim_rotation == 2'd0 && sim_col == 4'd5 && req_cycles == 2) wait_cyc = cyc;
        sim_ready = stray || (req_cycles >= 2 && !(mode == 4 && sim_rotation == 2'd0 && sim_col == 4'd5));
    end

    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ends right after edge 0 (the edge that samples start).
    task automatic do_start(input logic [3:0] blk, input logic [199:0] brd);
        @(negedge clk);
        start = 1'b1; cur_block = blk; cur_board = brd;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int at);
        at = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (done) begin at = cyc; break; end
        end
        checks++;
        assert (at >= 0) else begin
            errors++;
            $error("FAIL %s observed=no_done expected=done_within_300", tag);
        end
    endtask

    initial begin
        board_a = '0; board_a[5] = 1'b1; board_a[123] = 1'b1;
        board_e = '0; board_e[199] = 1'b1; board_e[0] = 1'b1;
        exp_b0 = '0; exp_b0[100] = 1'b1; exp_b0[150] = 1'b1; exp_b0[199] = 1'b1;
        exp_b3 = '0; for (int c = 0; c < 4; c++) exp_b3[190+c] = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 200'(busy), 200'(0));
        check("rst_flags", 200'({done, error, found, sim_request}), 200'(0));
        check("rst_best", 200'({best_col, best_rot, best_cleared, $unsigned(best_score)}), 200'(0));
        check("rst_best_board", best_board, 200'(0));
        rst_n = 1'b1;

        // Timing and strict-winner search: (rot 2, col 5) scores 64, others 32
        mode = 2;
        do_start(4'd3, board_a);
        @(negedge clk); check("t_busy_e0", 200'(busy), 200'(0));
        @(negedge clk); check("t_busy_e1", 200'(busy), 200'(1));
        check("t_req_e1", 200'({sim_request, sim_block, sim_col, sim_rotation}), 200'({1'b1, 4'd3, 4'd0, 2'd0}));
        check("t_sim_board", sim_board, board_a);
        repeat (119) @(negedge clk);
        check("t_done_e120", 200'(done), 200'(0));
        @(negedge clk);
        check("t_done_e121", 200'(done), 200'(1));
        check("m2_pos", 200'({found, error, best_rot, best_col}), 200'({1'b1, 1'b0, 2'd2, 4'd5}));
        check("m2_score", 200'($unsigned(best_score)), 200'(16'd64));
        check("m2_cleared", 200'(best_cleared), 200'(2));
        @(negedge clk);
        check("t_done_e122", 200'({done, busy}), 200'(0));

        // Height-weighted winner: (1,7) scores 64-11=53; (3,9) 96-48=48; others 32-10=22
        mode = 0;
        do_start(4'd7, '0);
        wait_done("m0_done", done_at);
        check("m0_pos", 200'({found, error, best_rot, best_col}), 200'({1'b1, 1'b0, 2'd1, 4'd7}));
        check("m0_score", 200'($unsigned(best_score)), 200'(16'd53));
        check("m0_cleared", 200'(best_cleared), 200'(2));
        check("m0_board", best_board, exp_b0);

        // No valid candidate
        mode = 1; req_pulses = 0;
        do_start(4'd1, board_a);
        wait_done("m1_done", done_at);
        check("m1_flags", 200'({found, error, best_rot, best_col}), 200'(0));
        check("m1_score", 200'($unsigned(best_score)), 200'(0));
        check("m1_pulses", 200'(req_pulses), 200'(40));

        // All equal negative scores (-4): first candidate wins
        mode = 3;
        do_start(4'd4, '0);
        wait_done("m3_done", done_at);
        check("m3_pos", 200'({found, best_rot, best_col}), 200'({1'b1, 2'd0, 4'd0}));
        check("m3_score", 200'($unsigned(best_score)), 200'(16'hfffc));
        check("m3_board", best_board, exp_b3);

        // Timeout on candidate 5, with a stray start mid-search
        mode = 4; wait_cyc = -1;
        do_start(4'd2, board_e);
        repeat (4) @(negedge clk);
        start = 1'b1; cur_block = 4'd9;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        check("m4_block_held", 200'(sim_block), 200'(2));
        wait_done("m4_done", done_at);
        check("m4_latency", 200'(done_at - wait_cyc), 200'(15));
        check("m4_flags", 200'({error, found, best_rot, best_col}), 200'({1'b1, 1'b0, 2'd0, 4'd0}));
        check("m4_score", 200'($unsigned(best_score)), 200'(0));
        check("m4_board", best_board, 200'(0));
        repeat (3) @(negedge clk);
        check("m4_idle", 200'({busy, sim_request}), 200'(0));

        // Reset during WAIT, then stray sim_ready in IDLE
        wait_cyc = -1;
        do_start(4'd5, board_e);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (wait_cyc >= 0) break;
        end
        check("r_in_wait", 200'({sim_request, found}), 200'({1'b1, 1'b1}));
        rst_n = 1'b0;
        #1;
        check("r_flags", 200'({busy, done, error, found, sim_request}), 200'(0));
        check("r_best", 200'({best_col, best_rot, best_cleared, $unsigned(best_score)}), 200'(0));
        check("r_sim", 200'({sim_block, sim_col, sim_rotation}), 200'(0));
        check("r_sim_board", sim_board, 200'(0));
        stray = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("r_stray_idle", 200'({busy, sim_request, done}), 200'(0));
        stray = 1'b0;
        mode = 3;
        do_start(4'd6, '0);
        wait_done("r_rerun_done", done_at);
        check("r_rerun", 200'({found, error, best_rot, best_col}), 200'({1'b1, 1'b0, 2'd0, 4'd0}));
        check("r_rerun_score", 200'($unsigned(best_score)), 200'(16'hfffc));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
